// File: rtl/wallace_mac_accum_if.sv
// Valid/ready bundle between the Wallace multiplier output and the burst accumulator.
// master = upstream/consumer side (drives beats and out_ready); slave = accumulator.
interface wallace_mac_accum_if #(
   parameter int PROD_W    = 32,
   parameter int ACC_W     = 40,
   parameter int BURST_LEN = 8
);
   localparam int CNT_W = $clog2(BURST_LEN + 1);

   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_prod;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_acc;
   logic [CNT_W-1:0]  out_count;
   logic              out_ovf;

   modport master (
      output in_valid, in_prod, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_prod, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_count, out_ovf
   );
endinterface

// File: rtl/wallace_mac_accum.sv
// Saturating burst accumulator for 32-bit multiplier products; presents the
// burst sum, beat count and sticky overflow on a valid/ready result port.
module wallace_mac_accum #(
   parameter int PROD_W    = 32,
   parameter int ACC_W     = 40,
   parameter int BURST_LEN = 8
) (
   input  logic                clk,
   input  logic                rst,
   wallace_mac_accum_if.slave  bus,
   output logic                busy
);
   localparam int CNT_W = $clog2(BURST_LEN + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] count;
   logic             ovf;
   logic             out_valid;
   logic [ACC_W:0]   sum;
   logic [CNT_W-1:0] count_nxt;
   logic             xfer;

   assign bus.in_ready  = (state != HOLD);
   assign busy          = (state != IDLE);
   assign bus.out_valid = out_valid;
   assign bus.out_acc   = acc;
   assign bus.out_count = count;
   assign bus.out_ovf   = ovf;

   assign xfer      = bus.in_valid & bus.in_ready;
   assign count_nxt = count + 1'b1;

   // One extra bit so the carry out of the accumulator flags saturation.
   always_comb begin
      sum = '0;
      sum = {1'b0, acc} + (ACC_W+1)'(bus.in_prod);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (xfer) begin
                  acc   <= ACC_W'(bus.in_prod);
                  count <= CNT_W'(1);
                  ovf   <= 1'b0;
                  if (bus.in_last || BURST_LEN == 1) begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (xfer) begin
                  if (sum[ACC_W]) begin
                     acc <= '1;
                     ovf <= 1'b1;
                  end else begin
                     acc <= sum[ACC_W-1:0];
                  end
                  count <= count_nxt;
                  if (bus.in_last || count_nxt == BURST_MAX) begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wallace_mac_accum.sv
// Drives one stimulus stream into a 40-bit and a 33-bit accumulator and checks
// both against a burst-sum model (plain sum of the accepted beats, clamped).
module tb_wallace_mac_accum;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy_a, busy_b;

   logic        in_valid = 1'b0;
   logic [31:0] in_prod  = '0;
   logic        in_last  = 1'b0;
   logic        out_ready = 1'b0;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   longint unsigned q[$];

   always #5 clk = ~clk;

   wallace_mac_accum_if #(.PROD_W(32), .ACC_W(40), .BURST_LEN(8)) bus_a ();
   wallace_mac_accum_if #(.PROD_W(32), .ACC_W(33), .BURST_LEN(8)) bus_b ();

   assign bus_a.in_valid  = in_valid;
   assign bus_a.in_prod   = in_prod;
   assign bus_a.in_last   = in_last;
   assign bus_a.out_ready = out_ready;
   assign bus_b.in_valid  = in_valid;
   assign bus_b.in_prod   = in_prod;
   assign bus_b.in_last   = in_last;
   assign bus_b.out_ready = out_ready;

   wallace_mac_accum #(.PROD_W(32), .ACC_W(40), .BURST_LEN(8)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a.slave), .busy(busy_a));
   wallace_mac_accum #(.PROD_W(32), .ACC_W(33), .BURST_LEN(8)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b.slave), .busy(busy_b));

   task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic longint unsigned model_total();
      longint unsigned t = 0;
      foreach (q[i]) t += q[i];
      return t;
   endfunction

   function automatic longint unsigned model_acc(input int w);
      longint unsigned mx = (64'd1 << w) - 1;
      longint unsigned t  = model_total();
      return (t > mx) ? mx : t;
   endfunction

   function automatic logic model_ovf(input int w);
      return model_total() > ((64'd1 << w) - 1);
   endfunction

   task automatic check_result(input string tag);
      check({tag, "_valid_a"}, bus_a.out_valid, 1);
      check({tag, "_valid_b"}, bus_b.out_valid, 1);
      check({tag, "_ready"},   bus_a.in_ready, 0);
      check({tag, "_busy"},    busy_a, 1);
      check({tag, "_acc_a"},   bus_a.out_acc, model_acc(40));
      check({tag, "_acc_b"},   bus_b.out_acc, model_acc(33));
      check({tag, "_cnt_a"},   bus_a.out_count, q.size());
      check({tag, "_cnt_b"},   bus_b.out_count, q.size());
      check({tag, "_ovf_a"},   bus_a.out_ovf, model_ovf(40));
      check({tag, "_ovf_b"},   bus_b.out_ovf, model_ovf(33));
   endtask

   // Called #1 after an edge; returns #1 after the accepting edge.
   task automatic send(input logic [31:0] p, input logic l);
      int unsigned k = 0;
      in_valid = 1'b1;
      in_prod  = p;
      in_last  = l;
      while (!bus_a.in_ready && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("accept_timeout", (k < 20), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      q.push_back(p);
   endtask

   // Result is pending: stall for hold_cycles with junk on the input, then drain.
   task automatic drain(input string tag, input int unsigned hold_cycles);
      check_result(tag);
      for (int unsigned c = 0; c < hold_cycles; c++) begin
         in_valid = c[0];
         in_prod  = $urandom;
         in_last  = $urandom_range(0, 1);
         @(posedge clk); #1;
         check_result({tag, "_hold"});
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_done_valid"}, bus_a.out_valid, 0);
      check({tag, "_done_ready"}, bus_a.in_ready, 1);
      check({tag, "_done_busy"},  busy_a, 0);
      q.delete();
   endtask

   task automatic burst(input string tag, input int unsigned len, input logic last_at_end,
                        input int unsigned kind, input int unsigned hold_cycles);
      logic [31:0] p;
      for (int unsigned i = 1; i <= len; i++) begin
         case (kind)
            0:       p = $urandom;
            1:       p = 32'($urandom_range(0, 255));
            2:       p = 32'hFFFF_FFFF;
            default: p = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom;
         endcase
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         send(p, (i == len) && last_at_end);
         if (i < len) check({tag, "_early_valid"}, bus_a.out_valid, 0);
      end
      drain(tag, hold_cycles);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Reset asserted mid-cycle during a partial burst.
      send(32'd7, 1'b0);
      send(32'd9, 1'b0);
      #3 rst = 1'b1;
      #1;
      check("rst_valid", bus_a.out_valid, 0);
      check("rst_acc",   bus_a.out_acc, 0);
      check("rst_cnt",   bus_a.out_count, 0);
      check("rst_ovf",   bus_a.out_ovf, 0);
      check("rst_ready", bus_a.in_ready, 1);
      check("rst_busy",  busy_a, 0);
      q.delete();
      @(posedge clk); #1 rst = 1'b0;

      // Full-length burst with no in_last.
      for (int unsigned i = 0; i < 8; i++) begin
         send(32'hFFFE_0001, 1'b0);
         if (i < 7) check("full_early_valid", bus_a.out_valid, 0);
      end
      check("full_acc_const", bus_a.out_acc, 64'h07_FFF0_0008);
      drain("full", 0);

      // Early termination with in_last, then a long stall.
      send(32'd1, 1'b0);
      send(32'd2, 1'b0);
      send(32'd3, 1'b1);
      check("short_acc_const", bus_a.out_acc, 6);
      drain("short", 5);

      // Saturation on the 33-bit instance, then a fresh burst clears ovf.
      for (int unsigned i = 0; i < 3; i++) send(32'hFFFF_FFFF, i == 2);
      check("sat_acc_const", bus_b.out_acc, 64'h1_FFFF_FFFF);
      drain("sat", 1);
      send(32'd5, 1'b1);
      check("sat_next_ovf", bus_b.out_ovf, 0);
      drain("sat_next", 0);

      // Reset pulse discards a partial burst.
      for (int unsigned i = 0; i < 4; i++) send(32'h10, 1'b0);
      rst = 1'b1;
      #2 rst = 1'b0;
      q.delete();
      send(32'd1, 1'b0);
      send(32'd1, 1'b1);
      check("post_rst_acc_const", bus_a.out_acc, 2);
      drain("post_rst", 0);

      // Single-beat burst.
      send(32'hDEAD_BEEF, 1'b1);
      drain("single", 2);

      // Randomized bursts.
      for (int unsigned b = 0; b < 40; b++) begin
         int unsigned len;
         len = $urandom_range(1, 8);
         burst("rand", len, (len < 8) ? 1'b1 : 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(0, 4));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
